// File: rtl/mem_access_unit.sv
// Load/store unit: formats one pipeline memory access into a single bus transaction and returns the formatted load data.
// Define LSU_ADDR_EXC_EN to report misaligned half/word accesses on addr_err instead of issuing them to the bus.
module mem_access_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  mem_control,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_stall,
    output logic        mem_done,
    output logic [31:0] load_result,
    output logic        addr_err,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    localparam int unsigned DW = 32;
    localparam int unsigned SW = 2;

`ifdef LSU_ADDR_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    localparam logic [SW-1:0] SZ_BYTE = 2'd0;
    localparam logic [SW-1:0] SZ_HALF = 2'd1;
    localparam logic [SW-1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
    typedef enum logic [2:0] {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW} op_t;

    state_t          state;
    op_t             op_q;

    op_t             acc_op;
    logic            accept;
    logic            acc_store;
    logic [SW-1:0]   acc_size;
    logic            acc_misaligned;
    logic [DW-1:0]   acc_addr;
    logic [DW-1:0]   acc_wdata;
    logic [3:0]      acc_wstrb;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [DW-1:0]   load_fmt;

    // Highest set control bit wins: lb has top priority, sw the lowest.
    function automatic op_t decode_op(input logic [7:0] ctrl);
        if (ctrl[7])      return OP_LB;
        else if (ctrl[6]) return OP_LBU;
        else if (ctrl[5]) return OP_LH;
        else if (ctrl[4]) return OP_LHU;
        else if (ctrl[3]) return OP_LW;
        else if (ctrl[2]) return OP_SB;
        else if (ctrl[1]) return OP_SH;
        else              return OP_SW;
    endfunction

    assign accept    = (state == S_IDLE) && mem_valid && (mem_control != 8'h00);
    assign mem_stall = accept || (state == S_REQ) || (state == S_WAIT);

    // Bus fields for the access being offered this cycle.
    always_comb begin
        acc_op         = decode_op(mem_control);
        acc_store      = 1'b0;
        acc_size       = SZ_WORD;
        acc_addr       = {mem_addr[DW-1:2], 2'b00};
        acc_wdata      = mem_wdata;
        acc_wstrb      = 4'b0000;
        acc_misaligned = 1'b0;
        case (acc_op)
            OP_LB, OP_LBU, OP_SB: begin
                acc_size  = SZ_BYTE;
                acc_addr  = mem_addr;
                acc_wdata = {4{mem_wdata[7:0]}};
                acc_wstrb = 4'b0001 << mem_addr[1:0];
            end
            OP_LH, OP_LHU, OP_SH: begin
                acc_size       = SZ_HALF;
                acc_addr       = {mem_addr[DW-1:1], 1'b0};
                acc_wdata      = {2{mem_wdata[15:0]}};
                acc_wstrb      = mem_addr[1] ? 4'b1100 : 4'b0011;
                acc_misaligned = mem_addr[0];
            end
            default: begin
                acc_wstrb      = 4'b1111;
                acc_misaligned = (mem_addr[1:0] != 2'b00);
            end
        endcase
        acc_store = (acc_op == OP_SB) || (acc_op == OP_SH) || (acc_op == OP_SW);
        if (!acc_store) begin
            acc_wstrb = 4'b0000;
        end
    end

    // Lane select and extension of the returned read data; stores yield zero.
    always_comb begin
        rd_byte  = data_rdata[{data_addr[1:0], 3'b000} +: 8];
        rd_half  = data_rdata[{data_addr[1], 4'b0000} +: 16];
        load_fmt = '0;
        case (op_q)
            OP_LB:   load_fmt = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  load_fmt = {24'h000000, rd_byte};
            OP_LH:   load_fmt = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  load_fmt = {16'h0000, rd_half};
            OP_LW:   load_fmt = data_rdata;
            default: load_fmt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            op_q        <= OP_LB;
            mem_done    <= 1'b0;
            addr_err    <= 1'b0;
            load_result <= '0;
            data_req    <= 1'b0;
            data_wr     <= 1'b0;
            data_size   <= SZ_BYTE;
            data_addr   <= '0;
            data_wdata  <= '0;
            data_wstrb  <= 4'b0000;
        end else begin
            mem_done <= 1'b0;
            addr_err <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q <= acc_op;
                        if (EXC_EN && acc_misaligned) begin
                            state       <= S_DONE;
                            mem_done    <= 1'b1;
                            addr_err    <= 1'b1;
                            load_result <= '0;
                        end else begin
                            state      <= S_REQ;
                            data_req   <= 1'b1;
                            data_wr    <= acc_store;
                            data_size  <= acc_size;
                            data_addr  <= acc_addr;
                            data_wdata <= acc_wdata;
                            data_wstrb <= acc_wstrb;
                        end
                    end
                end
                S_REQ: begin
                    if (data_addr_ok) begin
                        data_req <= 1'b0;
                        if (data_data_ok) begin
                            state       <= S_DONE;
                            mem_done    <= 1'b1;
                            load_result <= load_fmt;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (data_data_ok) begin
                        state       <= S_DONE;
                        mem_done    <= 1'b1;
                        load_result <= load_fmt;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit with an arithmetic reference model and a responsive bus slave.
module tb_mem_access_unit;

    logic        clk;
    logic        resetn;
    logic [7:0]  mem_control;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_stall;
    logic        mem_done;
    logic [31:0] load_result;
    logic        addr_err;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] load;
        logic [3:0]  wstrb;
        logic [1:0]  size;
        logic        wr;
        logic        exc;
    } exp_t;

    mem_access_unit dut (
        .clk          (clk),
        .resetn       (resetn),
        .mem_control  (mem_control),
        .mem_valid    (mem_valid),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_stall    (mem_stall),
        .mem_done     (mem_done),
        .load_result  (load_result),
        .addr_err     (addr_err),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected bus request and result derived from access size and byte offset.
    function automatic exp_t model(input logic [7:0] ctrl, input logic [31:0] addr,
                                   input logic [31:0] wd, input logic [31:0] rd);
        exp_t e;
        int b;
        int bytes;
        int off;
        int lane;
        logic [31:0] mask;
        logic [31:0] v;
        bit sgn;
        b = 7;
        while (b > 0 && !ctrl[b]) b--;
        e.wr = (b <= 2);
        case (b)
            7, 6, 2: e.size = 2'd0;
            5, 4, 1: e.size = 2'd1;
            default: e.size = 2'd2;
        endcase
        bytes = 1 << e.size;
        off   = int'(addr[1:0]) % bytes;
        e.exc = 1'b0;
`ifdef LSU_ADDR_EXC_EN
        e.exc = (off != 0);
`endif
        e.addr  = addr - 32'(off);
        lane    = int'(e.addr[1:0]);
        e.wstrb = e.wr ? 4'(((1 << bytes) - 1) << lane) : 4'b0000;
        case (e.size)
            2'd0:    e.wdata = (wd & 32'h0000_00FF) * 32'h0101_0101;
            2'd1:    e.wdata = (wd & 32'h0000_FFFF) * 32'h0001_0001;
            default: e.wdata = wd;
        endcase
        sgn  = (b == 7) || (b == 5);
        mask = (bytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * bytes)) - 32'h1);
        v    = (rd >> (8 * lane)) & mask;
        if (sgn && v[8 * bytes - 1]) v = v | ~mask;
        e.load = (e.wr || e.exc) ? 32'h0 : v;
        return e;
    endfunction

    // Present one access at the current negedge and play the bus slave with the given delays.
    task automatic run_access(input logic [7:0] ctrl, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rd, input int aok_dly, input int dok_dly);
        exp_t e;
        bit   done_seen;
        bit   addr_done;
        int   dwait;
        int   n;
        int   exp_lat;
        e         = model(ctrl, addr, wd, rd);
        done_seen = 1'b0;
        addr_done = 1'b0;
        dwait     = 0;
        exp_lat   = e.exc ? 0 : aok_dly + 1 + dok_dly;
        mem_valid   = 1'b1;
        mem_control = ctrl;
        mem_addr    = addr;
        mem_wdata   = wd;
        #1 check("stall_accept", 32'(mem_stall), 32'd1);
        @(negedge clk);
        mem_valid   = 1'b0;
        mem_control = 8'h00;
        for (n = 0; n < 60; n++) begin
            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            data_rdata   = $urandom;
            if (mem_done) begin
                done_seen = 1'b1;
                break;
            end
            check("stall_busy", 32'(mem_stall), 32'd1);
            if (!addr_done) begin
                check("req_high", 32'(data_req), 32'd1);
                check("req_addr", data_addr, e.addr);
                if (n == 0) begin
                    check("req_wr", 32'(data_wr), 32'(e.wr));
                    check("req_size", 32'(data_size), 32'(e.size));
                    check("req_wstrb", 32'(data_wstrb), 32'(e.wstrb));
                    if (e.wr) check("req_wdata", data_wdata, e.wdata);
                end
                if (n >= aok_dly) begin
                    data_addr_ok = 1'b1;
                    addr_done    = 1'b1;
                    if (dok_dly == 0) begin
                        data_data_ok = 1'b1;
                        data_rdata   = rd;
                    end
                end
            end else begin
                check("req_low", 32'(data_req), 32'd0);
                dwait++;
                if (dwait >= dok_dly) begin
                    data_data_ok = 1'b1;
                    data_rdata   = rd;
                end
            end
            @(negedge clk);
        end
        check("done_seen", 32'(done_seen), 32'd1);
        if (done_seen) begin
            check("latency", 32'(n), 32'(exp_lat));
            check("load_result", load_result, e.load);
            check("addr_err", 32'(addr_err), 32'(e.exc));
            check("stall_done", 32'(mem_stall), 32'd0);
            check("req_done", 32'(data_req), 32'd0);
            @(negedge clk);
            check("done_pulse", 32'(mem_done), 32'd0);
            check("result_hold", load_result, e.load);
        end
    endtask

    initial begin
        logic [7:0] ctrl;
        resetn       = 1'b0;
        mem_control  = 8'h00;
        mem_valid    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = '0;
        repeat (2) @(negedge clk);
        check("rst_stall", 32'(mem_stall), 32'd0);
        check("rst_done", 32'(mem_done), 32'd0);
        check("rst_req", 32'(data_req), 32'd0);
        check("rst_wr", 32'(data_wr), 32'd0);
        check("rst_err", 32'(addr_err), 32'd0);
        check("rst_size", 32'(data_size), 32'd0);
        check("rst_addr", data_addr, 32'd0);
        check("rst_wdata", data_wdata, 32'd0);
        check("rst_wstrb", 32'(data_wstrb), 32'd0);
        check("rst_result", load_result, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Directed cases from the access examples.
        run_access(8'h80, 32'h0000_1003, 32'h0, 32'h80FF_FF00, 1, 1);
        run_access(8'h02, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 0, 1);
        run_access(8'h08, 32'h0000_0040, 32'h0, 32'h1234_5678, 3, 1);
        run_access(8'h10, 32'h0000_0004, 32'h0, 32'h8001_0000, 0, 0);
        run_access(8'h08, 32'h0000_3001, 32'h0, 32'hCAFE_F00D, 0, 2);
        run_access(8'h20, 32'h0000_0102, 32'h0, 32'h8421_0000, 1, 0);
        run_access(8'h84, 32'h0000_0001, 32'h0, 32'h0000_7F00, 0, 0);

        // Idle: empty control and stray responses do nothing.
        mem_valid   = 1'b1;
        mem_control = 8'h00;
        #1 check("idle_no_stall", 32'(mem_stall), 32'd0);
        data_data_ok = 1'b1;
        @(negedge clk);
        check("idle_no_req", 32'(data_req), 32'd0);
        check("idle_no_done", 32'(mem_done), 32'd0);
        mem_valid    = 1'b0;
        data_data_ok = 1'b0;
        @(negedge clk);

        // Randomized accesses with random slave delays.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) ctrl = 8'($urandom_range(1, 255));
            else                           ctrl = 8'h01 << $urandom_range(0, 7);
            run_access(ctrl, $urandom, $urandom, $urandom,
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Reset while waiting for the response abandons the access.
        mem_valid   = 1'b1;
        mem_control = 8'h08;
        mem_addr    = 32'h0000_0100;
        @(negedge clk);
        mem_valid    = 1'b0;
        mem_control  = 8'h00;
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        check("wait_stall", 32'(mem_stall), 32'd1);
        check("wait_req", 32'(data_req), 32'd0);
        resetn = 1'b0;
        #1;
        check("midrst_stall", 32'(mem_stall), 32'd0);
        check("midrst_addr", data_addr, 32'd0);
        @(negedge clk);
        resetn       = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            data_data_ok = 1'b0;
            check("midrst_no_done", 32'(mem_done), 32'd0);
            check("midrst_idle", 32'(mem_stall), 32'd0);
        end
        check("midrst_result", load_result, 32'd0);

        // Unit is usable again after the abandoned access.
        run_access(8'h40, 32'h0000_0203, 32'h0, 32'hAB00_0000, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
